// File: rtl/tdm_demux8_if.sv
// Serial-in / 8-lane-frame-out bus for the TDM demultiplexer.
interface tdm_demux8_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned LANES  = 8;
   localparam int unsigned SLOT_W = 3;

   logic                    in_valid;
   logic                    in_sync;
   logic [WIDTH-1:0]        in_data;
   logic [LANES*WIDTH-1:0]  out_frame;
   logic                    frame_valid;
   logic                    locked;
   logic [SLOT_W-1:0]       slot;
   logic                    sync_err;

   // Sample source side: drives the serial stream, observes frames.
   modport master (
      output in_valid, in_sync, in_data,
      input  out_frame, frame_valid, locked, slot, sync_err
   );

   // Demultiplexer side.
   modport slave (
      input  in_valid, in_sync, in_data,
      output out_frame, frame_valid, locked, slot, sync_err
   );
endinterface

// File: rtl/tdm_demux8.sv
// Eight-lane TDM demultiplexer: collects one sample per valid beat into
// slots a..h (slot 0 marked by in_sync) and emits each completed frame
// as a registered 8-lane word with a one-cycle frame_valid pulse.
module tdm_demux8 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   tdm_demux8_if.slave   bus
);
   localparam int unsigned LANES  = 8;
   localparam int unsigned SLOT_W = 3;

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                        state_q, state_d;
   logic [SLOT_W-1:0]             slot_q, slot_d;
   logic [LANES-2:0][WIDTH-1:0]   capture_q;
   logic [LANES*WIDTH-1:0]        frame_q;
   logic                          frame_valid_q;
   logic                          sync_err_q;
   logic                          locked_q;

   logic                          cap_we;
   logic [SLOT_W-1:0]             cap_idx;
   logic                          frame_load;
   logic                          sync_err_d;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      cap_we     = 1'b0;
      cap_idx    = slot_q;
      frame_load = 1'b0;
      sync_err_d = 1'b0;
      case (state_q)
         HUNT: begin
            if (bus.in_valid && bus.in_sync) begin
               cap_we  = 1'b1;
               cap_idx = '0;
               slot_d  = SLOT_W'(1);
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (bus.in_valid) begin
               if (bus.in_sync && (slot_q != '0)) begin
                  // Misplaced sync: drop partial frame, restart at lane a.
                  sync_err_d = 1'b1;
                  cap_we     = 1'b1;
                  cap_idx    = '0;
                  slot_d     = SLOT_W'(1);
               end else if (slot_q == SLOT_W'(LANES-1)) begin
                  frame_load = 1'b1;
                  slot_d     = '0;
               end else begin
                  cap_we = 1'b1;
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Slot counter, capture lanes a..g, output frame and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q        <= '0;
         capture_q     <= '0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         frame_valid_q <= frame_load;
         sync_err_q    <= sync_err_d;
         locked_q      <= (state_d == LOCKED);
         if (frame_load) frame_q <= {bus.in_data, capture_q};
         for (int unsigned i = 0; i < LANES-1; i++) begin
            if (cap_we && (cap_idx == SLOT_W'(i))) capture_q[i] <= bus.in_data;
         end
      end
   end

   assign bus.out_frame   = frame_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.sync_err    = sync_err_q;
   assign bus.locked      = locked_q;
   assign bus.slot        = slot_q;
endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 with a frame scoreboard.
module tb_tdm_demux8;
   logic clk = 1'b0;
   logic rst = 1'b1;

   tdm_demux8_if #(.WIDTH(8)) bus ();

   tdm_demux8 #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cycle    = 0;
   int          err_seen = 0;
   int          c0;
   int          fv_a;
   logic [63:0] exp_q[$];
   int          fv_cyc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample just after the edge, score any frame.
   task automatic tick();
      logic [63:0] e;
      @(posedge clk);
      #1;
      cycle++;
      if (bus.frame_valid === 1'b1) begin
         fv_cyc.push_back(cycle);
         chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_frame", bus.out_frame, e);
         end
      end
      if (bus.sync_err === 1'b1) err_seen++;
      chk("fv_err_excl", 64'(bus.frame_valid & bus.sync_err), 64'd0);
   endtask

   task automatic beat(input logic s, input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_sync  = s;
      bus.in_data  = d;
      tick();
   endtask

   task automatic idle(input int n, input logic s);
      bus.in_valid = 1'b0;
      bus.in_sync  = s;
      bus.in_data  = 8'hEE;
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [63:0] ramp(input logic [7:0] base);
      logic [63:0] f;
      for (int i = 0; i < 8; i++) f[i*8 +: 8] = base + 8'(i);
      return f;
   endfunction

   // Eight beats base..base+7, expected frame pushed with the last beat.
   task automatic send_frame(input logic [7:0] base, input logic sync_first);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) exp_q.push_back(ramp(base));
         beat((i == 0) ? sync_first : 1'b0, base + 8'(i));
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      bus.in_data  = '0;

      // Reset state
      rst = 1'b1;
      idle(2, 1'b0);
      chk("rst_frame",  bus.out_frame, 64'd0);
      chk("rst_fv",     64'(bus.frame_valid), 64'd0);
      chk("rst_locked", 64'(bus.locked), 64'd0);
      chk("rst_slot",   64'(bus.slot), 64'd0);
      chk("rst_err",    64'(bus.sync_err), 64'd0);
      rst = 1'b0;

      // Basic frame 0x10..0x17
      beat(1'b1, 8'h10);
      chk("lock_rise", 64'(bus.locked), 64'd1);
      chk("lock_slot", 64'(bus.slot), 64'd1);
      for (int i = 1; i < 7; i++) beat(1'b0, 8'h10 + 8'(i));
      chk("pre_fv", 64'(bus.frame_valid), 64'd0);
      exp_q.push_back(64'h1716151413121110);
      beat(1'b0, 8'h17);
      chk("t1_fv",     64'(bus.frame_valid), 64'd1);
      chk("t1_frame",  bus.out_frame, 64'h1716151413121110);
      chk("t1_locked", 64'(bus.locked), 64'd1);
      chk("t1_slot",   64'(bus.slot), 64'd0);
      idle(1, 1'b0);
      chk("fv_pulse", 64'(bus.frame_valid), 64'd0);
      chk("hold_frame", bus.out_frame, 64'h1716151413121110);

      // Non-sync beats dropped while hunting, then a synced frame
      rst = 1'b1;
      idle(1, 1'b0);
      rst = 1'b0;
      beat(1'b0, 8'hAA);
      beat(1'b0, 8'hBB);
      chk("hunt_locked", 64'(bus.locked), 64'd0);
      chk("hunt_slot",   64'(bus.slot), 64'd0);
      c0 = cycle + 1;
      send_frame(8'h00, 1'b1);
      idle(1, 1'b0);
      chk("t2_frame", bus.out_frame, 64'h0706050403020100);
      chk("t2_lat",   64'(fv_cyc[$] - c0), 64'd7);

      // Resync mid-frame
      err_seen = 0;
      beat(1'b1, 8'h31);
      beat(1'b0, 8'h32);
      beat(1'b0, 8'h33);
      beat(1'b1, 8'h55);
      chk("rs_err",  64'(bus.sync_err), 64'd1);
      chk("rs_fv",   64'(bus.frame_valid), 64'd0);
      chk("rs_slot", 64'(bus.slot), 64'd1);
      for (int i = 1; i < 8; i++) begin
         if (i == 7) exp_q.push_back(64'h5C5B5A5958575655);
         beat(1'b0, 8'h55 + 8'(i));
         if (i == 1) chk("rs_err_pulse", 64'(bus.sync_err), 64'd0);
      end
      idle(1, 1'b0);
      chk("rs_err_cnt", 64'(err_seen), 64'd1);
      chk("rs_frame",   bus.out_frame, 64'h5C5B5A5958575655);

      // Stall of 5 cycles between slot 3 and slot 4 (sync toggled while idle)
      c0 = cycle + 1;
      for (int i = 0; i < 4; i++) beat((i == 0), 8'h60 + 8'(i));
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_sync = 1'(i % 2);
         tick();
         chk("gap_slot", 64'(bus.slot), 64'd4);
         chk("gap_fv",   64'(bus.frame_valid), 64'd0);
      end
      for (int i = 4; i < 8; i++) begin
         if (i == 7) exp_q.push_back(64'h6766656463626160);
         beat(1'b0, 8'h60 + 8'(i));
      end
      idle(1, 1'b0);
      chk("gap_lat",   64'(fv_cyc[$] - c0), 64'd12);
      chk("gap_frame", bus.out_frame, 64'h6766656463626160);

      // Two back-to-back frames, sync only on the first
      err_seen = 0;
      send_frame(8'h70, 1'b1);
      fv_a = fv_cyc[$];
      send_frame(8'h80, 1'b0);
      idle(1, 1'b0);
      chk("b2b_space", 64'(fv_cyc[$] - fv_a), 64'd8);
      chk("b2b_frame", bus.out_frame, 64'h8786858483828180);
      chk("b2b_err",   64'(err_seen), 64'd0);

      // Reset mid-frame, asserted alongside a sync beat
      for (int i = 0; i < 6; i++) beat((i == 0), 8'hA0 + 8'(i));
      chk("mid_slot", 64'(bus.slot), 64'd6);
      rst = 1'b1;
      beat(1'b1, 8'hA6);
      rst = 1'b0;
      chk("mr_frame",  bus.out_frame, 64'd0);
      chk("mr_locked", 64'(bus.locked), 64'd0);
      chk("mr_slot",   64'(bus.slot), 64'd0);
      chk("mr_fv",     64'(bus.frame_valid), 64'd0);
      chk("mr_err",    64'(bus.sync_err), 64'd0);
      beat(1'b0, 8'h99);
      chk("mr_drop_locked", 64'(bus.locked), 64'd0);
      chk("mr_drop_slot",   64'(bus.slot), 64'd0);
      idle(3, 1'b0);

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
